// File: rtl/mem_port_responder_pkg.sv
// memport_pkg: shared types and constants for the core-side memory port responder.
// Holds the word/address types, FSM state enum, grant tag and the byte-enable constant.
package memport_pkg;

  typedef logic [31:0] regval_t;
  typedef logic [24:0] addr_t;

  typedef enum logic [1:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    WR_ISSUE
  } memport_state_t;

  typedef enum logic {
    GRANT_RD,
    GRANT_WR
  } grant_t;

  localparam logic [3:0] BYTEENABLE_ALL = 4'hF;

endpackage

// File: rtl/mem_port_responder_if.sv
// Bundles for the responder: core-side four-phase port pair and Avalon-MM master side.
// memport_core_if: master = requester (cache/core), slave = responder.
// memport_avm_if: master = responder, slave = SDRAM controller.
interface memport_core_if #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 32
);
  logic              read_n;
  logic [ADDR_W-1:0] read_address;
  logic [DATA_W-1:0] read_data;
  logic              data_ready_n;
  logic              write_n;
  logic [ADDR_W-1:0] write_address;
  logic [DATA_W-1:0] write_data;
  logic              data_written_n;

  modport master (
    output read_n, read_address,
    output write_n, write_address, write_data,
    input  read_data, data_ready_n, data_written_n
  );

  modport slave (
    input  read_n, read_address,
    input  write_n, write_address, write_data,
    output read_data, data_ready_n, data_written_n
  );
endinterface

interface memport_avm_if #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic              avm_write;
  logic [DATA_W-1:0] avm_writedata;
  logic [3:0]        avm_byteenable;
  logic              avm_waitrequest;
  logic [DATA_W-1:0] avm_readdata;
  logic              avm_readdatavalid;

  modport master (
    output avm_address, avm_read, avm_write,
    output avm_writedata, avm_byteenable,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid
  );

  modport slave (
    input  avm_address, avm_read, avm_write,
    input  avm_writedata, avm_byteenable,
    output avm_waitrequest, avm_readdata, avm_readdatavalid
  );
endinterface

// File: rtl/mem_port_responder_handshake.sv
// memport_handshake: four-phase done-flag tracker for one core-side port.
// Ports: clock, reset_n, req_n (low-active request), complete (pulse),
// done_n (held low until req_n is sampled high), pending (grantable request).
module memport_handshake
  import memport_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic req_n,
  input  logic complete,
  output logic done_n,
  output logic pending
);

  logic req_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      req_q  <= 1'b1;
      done_n <= 1'b1;
    end else begin
      req_q <= req_n;
      if (complete)
        done_n <= 1'b0;
      else if (req_n)
        done_n <= 1'b1;
    end
  end

  // complete masks the cycle before done_n drops so the port is not regranted
  assign pending = !req_q && done_n && !complete;

endmodule

// File: rtl/mem_port_responder.sv
// mem_port_responder: completes core-side read/write requests as one Avalon-MM master.
// Ports: clock, reset_n, core (memport_core_if.slave), avm (memport_avm_if.master).
// Optional: MEM_PORT_POSTED_WRITE_EN adds a one-entry posted write buffer.
module mem_port_responder
  import memport_pkg::*;
#(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 32
) (
  input  logic          clock,
  input  logic          reset_n,
  memport_core_if.slave core,
  memport_avm_if.master avm
);

  localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'(3);

  memport_state_t state_q, state_d;
  grant_t         last_q;

  logic [ADDR_W-1:0] addr_q, rd_addr, wr_addr;
  logic [DATA_W-1:0] wdata_q, rdata_q, wr_data;
  logic rd_cap_q, rd_beat, wr_accept;
  logic rd_pend, wr_pend, rd_done_n, wr_done_n;
  logic wr_cmpl, rd_req, wr_req, rd_first;
  logic grant_rd, grant_wr;

  assign rd_beat   = state_q == RD_WAIT && avm.avm_readdatavalid;
  assign wr_accept = state_q == WR_ISSUE && !avm.avm_waitrequest;
  assign rd_addr   = core.read_address & ALIGN;

  memport_handshake u_rd (
    .clock    (clock),
    .reset_n  (reset_n),
    .req_n    (core.read_n),
    .complete (rd_cap_q),
    .done_n   (rd_done_n),
    .pending  (rd_pend)
  );

  memport_handshake u_wr (
    .clock    (clock),
    .reset_n  (reset_n),
    .req_n    (core.write_n),
    .complete (wr_cmpl),
    .done_n   (wr_done_n),
    .pending  (wr_pend)
  );

`ifdef MEM_PORT_POSTED_WRITE_EN
  logic              wb_valid_q, wb_ack_q, wb_latch, rd_hazard;
  logic [ADDR_W-1:0] wb_addr_q;
  logic [DATA_W-1:0] wb_data_q;

  assign wb_latch = wr_pend && !wb_valid_q;
  // a read may not overtake a buffered (or just-latching) write to its word
  assign rd_hazard =
    (wb_valid_q && rd_addr == wb_addr_q) ||
    (wb_latch && rd_addr == (core.write_address & ALIGN));
  assign wr_cmpl  = wb_ack_q;
  assign wr_req   = wb_valid_q;
  assign rd_req   = rd_pend && !rd_hazard;
  assign wr_addr  = wb_addr_q;
  assign wr_data  = wb_data_q;
  assign rd_first = rd_req && !wr_req;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wb_valid_q <= 1'b0;
      wb_ack_q   <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
    end else begin
      wb_ack_q <= wb_latch;
      if (grant_wr)
        wb_valid_q <= 1'b0;
      else if (wb_latch)
        wb_valid_q <= 1'b1;
      if (wb_latch) begin
        wb_addr_q <= core.write_address & ALIGN;
        wb_data_q <= core.write_data;
      end
    end
  end
`else
  assign wr_cmpl  = wr_accept;
  assign wr_req   = wr_pend;
  assign rd_req   = rd_pend;
  assign wr_addr  = core.write_address & ALIGN;
  assign wr_data  = core.write_data;
  assign rd_first = rd_req && (!wr_req || last_q == GRANT_WR);
`endif

  always_comb begin
    state_d  = state_q;
    grant_rd = 1'b0;
    grant_wr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rd_first) begin
          grant_rd = 1'b1;
          state_d  = RD_ISSUE;
        end else if (wr_req) begin
          grant_wr = 1'b1;
          state_d  = WR_ISSUE;
        end
      end
      RD_ISSUE: if (!avm.avm_waitrequest) state_d = RD_WAIT;
      RD_WAIT:  if (avm.avm_readdatavalid) state_d = IDLE;
      WR_ISSUE: if (wr_accept) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      last_q   <= GRANT_WR;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rd_cap_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_cap_q <= rd_beat;
      if (rd_beat)
        rdata_q <= avm.avm_readdata;
      if (grant_rd) begin
        addr_q <= rd_addr;
        last_q <= GRANT_RD;
      end
      if (grant_wr) begin
        addr_q  <= wr_addr;
        wdata_q <= wr_data;
        last_q  <= GRANT_WR;
      end
    end
  end

  assign core.read_data      = rdata_q;
  assign core.data_ready_n   = rd_done_n;
  assign core.data_written_n = wr_done_n;

  assign avm.avm_address    = addr_q;
  assign avm.avm_read       = state_q == RD_ISSUE;
  assign avm.avm_write      = state_q == WR_ISSUE;
  assign avm.avm_writedata  = wdata_q;
  assign avm.avm_byteenable = BYTEENABLE_ALL;

endmodule

// File: tb/tb_mem_port_responder.sv
// tb_mem_port_responder: directed self-checking bench for mem_port_responder.
// Drives both core ports and plays the Avalon slave by hand.
module tb_mem_port_responder;

  logic clock;
  logic reset_n;
  int   n_cmp;
  int   n_bad;
  int   k;
  int   n_wr_cyc;

  memport_core_if core_bus ();
  memport_avm_if  avm_bus ();

  mem_port_responder dut (
    .clock   (clock),
    .reset_n (reset_n),
    .core    (core_bus),
    .avm     (avm_bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_avm(output int kind);
    kind = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (avm_bus.avm_read) begin
        kind = 1;
        break;
      end
      if (avm_bus.avm_write) begin
        kind = 2;
        break;
      end
    end
  endtask

  task automatic serve_read(input logic [31:0] data);
    tick;
    avm_bus.avm_readdatavalid = 1'b1;
    avm_bus.avm_readdata      = data;
    tick;
    avm_bus.avm_readdatavalid = 1'b0;
    avm_bus.avm_readdata      = '0;
  endtask

  task automatic wait_rd_done(input string tag);
    int n;
    n = 0;
    while (core_bus.data_ready_n !== 1'b0 && n < 20) begin
      tick;
      n++;
    end
    chk(tag, 64'(core_bus.data_ready_n), 64'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset_n = 1'b0;
    core_bus.read_n        = 1'b1;
    core_bus.read_address  = '0;
    core_bus.write_n       = 1'b1;
    core_bus.write_address = '0;
    core_bus.write_data    = '0;
    avm_bus.avm_waitrequest   = 1'b0;
    avm_bus.avm_readdata      = '0;
    avm_bus.avm_readdatavalid = 1'b0;
    repeat (3) tick;

    chk("rst_ready_n", 64'(core_bus.data_ready_n), 64'd1);
    chk("rst_written_n", 64'(core_bus.data_written_n), 64'd1);
    chk("rst_read_data", 64'(core_bus.read_data), 64'd0);
    chk("rst_avm_read", 64'(avm_bus.avm_read), 64'd0);
    chk("rst_avm_write", 64'(avm_bus.avm_write), 64'd0);
    chk("rst_avm_addr", 64'(avm_bus.avm_address), 64'd0);
    chk("rst_avm_wdata", 64'(avm_bus.avm_writedata), 64'd0);
    chk("rst_byteen", 64'(avm_bus.avm_byteenable), 64'hF);
    reset_n = 1'b1;
    tick;

`ifndef MEM_PORT_POSTED_WRITE_EN
    // contention right after reset: read first, then write
    core_bus.read_address  = 25'h000010;
    core_bus.write_address = 25'h000020;
    core_bus.write_data    = 32'hAAAA5555;
    core_bus.read_n  = 1'b0;
    core_bus.write_n = 1'b0;
    wait_avm(k);
    chk("cont1_first_rd", 64'(k), 64'd1);
    chk("cont1_rd_addr", 64'(avm_bus.avm_address), 64'h10);
    serve_read(32'h11111111);
    wait_avm(k);
    chk("cont1_second_wr", 64'(k), 64'd2);
    chk("cont1_wr_addr", 64'(avm_bus.avm_address), 64'h20);
    chk("cont1_wr_data", 64'(avm_bus.avm_writedata), 64'hAAAA5555);
    tick;
    chk("cont1_written_n", 64'(core_bus.data_written_n), 64'd0);
    chk("cont1_ready_n", 64'(core_bus.data_ready_n), 64'd0);
    chk("cont1_rdata", 64'(core_bus.read_data), 64'h11111111);
    core_bus.read_n  = 1'b1;
    core_bus.write_n = 1'b1;
    tick;
    chk("cont1_rel_rd", 64'(core_bus.data_ready_n), 64'd1);
    chk("cont1_rel_wr", 64'(core_bus.data_written_n), 64'd1);
    tick;
`endif

    // single read with exact latency, then done hold for 10 cycles
    core_bus.read_address = 25'h000104;
    core_bus.read_n = 1'b0;
    tick;
    chk("rd_e1_avm_read", 64'(avm_bus.avm_read), 64'd0);
    tick;
    chk("rd_e2_avm_read", 64'(avm_bus.avm_read), 64'd1);
    chk("rd_e2_addr", 64'(avm_bus.avm_address), 64'h104);
    tick;
    chk("rd_e3_avm_read", 64'(avm_bus.avm_read), 64'd0);
    avm_bus.avm_readdatavalid = 1'b1;
    avm_bus.avm_readdata      = 32'hCAFEF00D;
    tick;
    avm_bus.avm_readdatavalid = 1'b0;
    avm_bus.avm_readdata      = 32'h0BADBAD0;
    chk("rd_e4_ready_n", 64'(core_bus.data_ready_n), 64'd1);
    tick;
    chk("rd_e5_ready_n", 64'(core_bus.data_ready_n), 64'd0);
    chk("rd_e5_rdata", 64'(core_bus.read_data), 64'hCAFEF00D);
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("hold_ready_n", 64'(core_bus.data_ready_n), 64'd0);
      chk("hold_avm_read", 64'(avm_bus.avm_read), 64'd0);
      chk("hold_rdata", 64'(core_bus.read_data), 64'hCAFEF00D);
    end
    core_bus.read_n = 1'b1;
    tick;
    chk("rd_release", 64'(core_bus.data_ready_n), 64'd1);
    tick;

`ifndef MEM_PORT_POSTED_WRITE_EN
    // last grant was a read, so contention now favours the write
    core_bus.read_address  = 25'h000030;
    core_bus.write_address = 25'h000040;
    core_bus.write_data    = 32'h55AA55AA;
    core_bus.read_n  = 1'b0;
    core_bus.write_n = 1'b0;
    wait_avm(k);
    chk("cont2_first_wr", 64'(k), 64'd2);
    chk("cont2_wr_addr", 64'(avm_bus.avm_address), 64'h40);
    tick;
    wait_avm(k);
    chk("cont2_second_rd", 64'(k), 64'd1);
    chk("cont2_rd_addr", 64'(avm_bus.avm_address), 64'h30);
    serve_read(32'h22222222);
    wait_rd_done("cont2_rd_done");
    chk("cont2_rdata", 64'(core_bus.read_data), 64'h22222222);
    chk("cont2_written_n", 64'(core_bus.data_written_n), 64'd0);
    core_bus.read_n  = 1'b1;
    core_bus.write_n = 1'b1;
    repeat (2) tick;

    // write with slave stalling three cycles
    core_bus.write_address = 25'h000203;
    core_bus.write_data    = 32'h12345678;
    avm_bus.avm_waitrequest = 1'b1;
    core_bus.write_n = 1'b0;
    n_wr_cyc = 0;
    tick;
    chk("wr_e1_avm_write", 64'(avm_bus.avm_write), 64'd0);
    tick;
    for (int i = 0; i < 4; i++) begin
      if (avm_bus.avm_write) n_wr_cyc++;
      if (i == 0) begin
        chk("wr_addr_aligned", 64'(avm_bus.avm_address), 64'h200);
        chk("wr_wdata", 64'(avm_bus.avm_writedata), 64'h12345678);
      end
      if (i == 3) begin
        chk("wr_not_done_yet", 64'(core_bus.data_written_n), 64'd1);
        avm_bus.avm_waitrequest = 1'b0;
      end
      tick;
    end
    chk("wr_held_cycles", 64'(n_wr_cyc), 64'd4);
    chk("wr_after_accept", 64'(avm_bus.avm_write), 64'd0);
    chk("wr_written_n", 64'(core_bus.data_written_n), 64'd0);
    core_bus.write_n = 1'b1;
    tick;
    chk("wr_release", 64'(core_bus.data_written_n), 64'd1);
    tick;
`else
    // posted write, then a read of the same word one cycle later
    core_bus.write_address = 25'h000100;
    core_bus.write_data    = 32'hDEADBEEF;
    core_bus.write_n = 1'b0;
    tick;
    core_bus.read_address = 25'h000100;
    core_bus.read_n = 1'b0;
    wait_avm(k);
    chk("post_first_wr", 64'(k), 64'd2);
    chk("post_written_n", 64'(core_bus.data_written_n), 64'd0);
    chk("post_wr_addr", 64'(avm_bus.avm_address), 64'h100);
    chk("post_wr_data", 64'(avm_bus.avm_writedata), 64'hDEADBEEF);
    tick;
    wait_avm(k);
    chk("post_then_rd", 64'(k), 64'd1);
    chk("post_rd_addr", 64'(avm_bus.avm_address), 64'h100);
    serve_read(32'h0BADF00D);
    wait_rd_done("post_rd_done");
    chk("post_rdata", 64'(core_bus.read_data), 64'h0BADF00D);
    core_bus.read_n  = 1'b1;
    core_bus.write_n = 1'b1;
    repeat (2) tick;
`endif

    // reset while waiting for read data; late data must be ignored
    core_bus.read_address = 25'h000400;
    core_bus.read_n = 1'b0;
    wait_avm(k);
    chk("rst_mid_rd_issue", 64'(k), 64'd1);
    tick;
    reset_n = 1'b0;
    tick;
    chk("rst_mid_rdata", 64'(core_bus.read_data), 64'd0);
    chk("rst_mid_ready_n", 64'(core_bus.data_ready_n), 64'd1);
    reset_n = 1'b1;
    core_bus.read_n = 1'b1;
    avm_bus.avm_readdatavalid = 1'b1;
    avm_bus.avm_readdata      = 32'hFFFFFFFF;
    tick;
    avm_bus.avm_readdatavalid = 1'b0;
    avm_bus.avm_readdata      = '0;
    repeat (2) tick;
    chk("late_rdv_rdata", 64'(core_bus.read_data), 64'd0);
    chk("late_rdv_ready_n", 64'(core_bus.data_ready_n), 64'd1);
    chk("late_rdv_avm_read", 64'(avm_bus.avm_read), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
